// File: rtl/posix_time_pkg.sv
// Shared constants and types for the POSIX-time to hours/minutes/seconds converter.
package posix_time_pkg;

   localparam int unsigned SEC_IN_MIN   = 60;
   localparam int unsigned SEC_IN_HOUR  = 3600;
   localparam int unsigned SEC_IN_DAY   = 86400;
   localparam int unsigned DAYS_IN_WEEK = 7;
   localparam int unsigned EPOCH_DOW    = 4;   // 1970-01-01 was a Thursday

   typedef enum logic [2:0] {
      IDLE,
      P_DAY,
      P_HOUR,
      P_MIN,
      P_DOW,
      DONE
   } conv_state_t;

   typedef struct packed {
      logic [4:0] hour;
      logic [5:0] min;
      logic [5:0] sec;
   } hms_t;

endpackage

// File: rtl/seq_udiv.sv
// Multi-cycle restoring unsigned divider: one load cycle, then W shift/subtract iterations.
// quotient/remainder are valid in the cycle done is high (they show that iteration's result).
module seq_udiv #(
   parameter int W = 32
) (
   input  logic         clk_i,
   input  logic         rst_i,
   input  logic         start,
   input  logic [W-1:0] dividend,
   input  logic [W-1:0] divisor,
   output logic [W-1:0] quotient,
   output logic [W-1:0] remainder,
   output logic         done
);

   localparam int CW = $clog2(W) + 1;

   logic [W-1:0]  quo_q;
   logic [W-1:0]  rem_q;
   logic [W-1:0]  dvs_q;
   logic [CW-1:0] cnt_q;
   logic          run_q;

   logic [W:0]    trial;
   logic [W:0]    diff;
   logic          q_bit;
   logic [W-1:0]  rem_nx;
   logic [W-1:0]  quo_nx;

   // Partial remainder stays below the divisor, so W+1 bits hold the trial and its sign.
   always_comb begin
      trial  = {rem_q, quo_q[W-1]};
      diff   = trial - {1'b0, dvs_q};
      q_bit  = ~diff[W];
      rem_nx = q_bit ? diff[W-1:0] : trial[W-1:0];
      quo_nx = {quo_q[W-2:0], q_bit};
   end

   assign quotient  = quo_nx;
   assign remainder = rem_nx;
   assign done      = run_q && (cnt_q == CW'(W - 1));

   // NOTE: state registers use non-blocking assignment so every flop samples pre-edge values.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         quo_q <= '0;
         rem_q <= '0;
         dvs_q <= '0;
         cnt_q <= '0;
         run_q <= 1'b0;
      end else if (start) begin
         quo_q <= dividend;
         rem_q <= '0;
         dvs_q <= divisor;
         cnt_q <= '0;
         run_q <= 1'b1;
      end else if (run_q) begin
         quo_q <= quo_nx;
         rem_q <= rem_nx;
         cnt_q <= cnt_q + 1'b1;
         if (done) run_q <= 1'b0;
      end
   end

endmodule

// File: rtl/posix_time_to_hms.sv
// Converts local POSIX seconds to h:m:s, day-of-week and days-since-epoch using four
// sequential passes through one shared divider; fixed latency of 4*(TIME_W+1)+1 cycles.
module posix_time_to_hms
   import posix_time_pkg::*;
#(
   parameter int TIME_W = 32
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic [TIME_W-1:0] posix_time_i,
   input  logic              start_i,
   output logic              busy_o,
   output logic              valid_o,
   output logic [4:0]        hour_o,
   output logic [5:0]        min_o,
   output logic [5:0]        sec_o,
   output logic [2:0]        dow_o,
   output logic [15:0]       days_o
);

   conv_state_t       state_q;
   logic              first_q;
   logic [TIME_W-1:0] t_q;

   logic [15:0]       days_s;
   logic [16:0]       sod_s;
   logic [11:0]       remh_s;
   logic [4:0]        hour_s;
   logic [5:0]        min_s;
   logic [5:0]        sec_s;

   hms_t              hms_q;
   logic [2:0]        dow_q;
   logic [15:0]       days_q;

   logic [TIME_W-1:0] div_dividend;
   logic [TIME_W-1:0] div_divisor;
   logic [TIME_W-1:0] div_quotient;
   logic [TIME_W-1:0] div_remainder;
   logic              div_done;
   logic              div_start;

   // The first cycle of each pass loads the divider with that pass's operands.
   assign div_start = first_q;

   always_comb begin
      div_dividend = '0;
      div_divisor  = TIME_W'(1);
      unique case (state_q)
         P_DAY: begin
            div_dividend = t_q;
            div_divisor  = TIME_W'(SEC_IN_DAY);
         end
         P_HOUR: begin
            div_dividend = TIME_W'(sod_s);
            div_divisor  = TIME_W'(SEC_IN_HOUR);
         end
         P_MIN: begin
            div_dividend = TIME_W'(remh_s);
            div_divisor  = TIME_W'(SEC_IN_MIN);
         end
         P_DOW: begin
            div_dividend = TIME_W'(days_s) + TIME_W'(EPOCH_DOW);
            div_divisor  = TIME_W'(DAYS_IN_WEEK);
         end
         default: ;
      endcase
   end

   seq_udiv #(
      .W(TIME_W)
   ) u_div (
      .clk_i     (clk_i),
      .rst_i     (rst_i),
      .start     (div_start),
      .dividend  (div_dividend),
      .divisor   (div_divisor),
      .quotient  (div_quotient),
      .remainder (div_remainder),
      .done      (div_done)
   );

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q <= IDLE;
         first_q <= 1'b0;
         t_q     <= '0;
         days_s  <= '0;
         sod_s   <= '0;
         remh_s  <= '0;
         hour_s  <= '0;
         min_s   <= '0;
         sec_s   <= '0;
         hms_q   <= '0;
         dow_q   <= 3'(EPOCH_DOW);
         days_q  <= '0;
         busy_o  <= 1'b0;
         valid_o <= 1'b0;
      end else begin
         valid_o <= 1'b0;
         first_q <= 1'b0;
         unique case (state_q)
            IDLE: begin
               if (start_i) begin
                  t_q     <= posix_time_i;
                  first_q <= 1'b1;
                  busy_o  <= 1'b1;
                  state_q <= P_DAY;
               end
            end
            P_DAY: begin
               if (div_done) begin
                  days_s  <= div_quotient[15:0];
                  sod_s   <= div_remainder[16:0];
                  first_q <= 1'b1;
                  state_q <= P_HOUR;
               end
            end
            P_HOUR: begin
               if (div_done) begin
                  hour_s  <= div_quotient[4:0];
                  remh_s  <= div_remainder[11:0];
                  first_q <= 1'b1;
                  state_q <= P_MIN;
               end
            end
            P_MIN: begin
               if (div_done) begin
                  min_s   <= div_quotient[5:0];
                  sec_s   <= div_remainder[5:0];
                  first_q <= 1'b1;
                  state_q <= P_DOW;
               end
            end
            P_DOW: begin
               // All visible outputs change together so a reader never sees a mixed result.
               if (div_done) begin
                  hms_q   <= '{hour: hour_s, min: min_s, sec: sec_s};
                  dow_q   <= div_remainder[2:0];
                  days_q  <= days_s;
                  valid_o <= 1'b1;
                  busy_o  <= 1'b0;
                  state_q <= DONE;
               end
            end
            DONE: state_q <= IDLE;
            default: state_q <= IDLE;
         endcase
      end
   end

   assign hour_o = hms_q.hour;
   assign min_o  = hms_q.min;
   assign sec_o  = hms_q.sec;
   assign dow_o  = dow_q;
   assign days_o = days_q;

endmodule

// File: tb/tb_posix_time_to_hms.sv
// Directed-vector bench for posix_time_to_hms: latency, known dates, ignored starts, reset abort.
module tb_posix_time_to_hms;

   logic        clk_i = 1'b0;
   logic        rst_i;
   logic [31:0] posix_time_i;
   logic        start_i;
   logic        busy_o;
   logic        valid_o;
   logic [4:0]  hour_o;
   logic [5:0]  min_o;
   logic [5:0]  sec_o;
   logic [2:0]  dow_o;
   logic [15:0] days_o;

   int checks    = 0;
   int failures  = 0;
   int valid_cnt = 0;

   posix_time_to_hms #(
      .TIME_W(32)
   ) dut (
      .clk_i        (clk_i),
      .rst_i        (rst_i),
      .posix_time_i (posix_time_i),
      .start_i      (start_i),
      .busy_o       (busy_o),
      .valid_o      (valid_o),
      .hour_o       (hour_o),
      .min_o        (min_o),
      .sec_o        (sec_o),
      .dow_o        (dow_o),
      .days_o       (days_o)
   );

   always #5 clk_i = ~clk_i;

   always @(negedge clk_i) if (valid_o === 1'b1) valid_cnt++;

   // Start a conversion in cycle 0, optionally pulse a second start at extra_cyc,
   // then expect valid_o in cycle 133 with the given result, held afterwards.
   task automatic run_conv(input string name, input logic [31:0] t,
                           input int exp_h, input int exp_m, input int exp_s,
                           input int exp_dow, input int exp_days,
                           input int extra_cyc, input logic [31:0] extra_t);
      int lat;
      int v0;
      @(negedge clk_i);
      v0           = valid_cnt;
      posix_time_i = t;
      start_i      = 1'b1;
      @(negedge clk_i);
      start_i      = 1'b0;
      posix_time_i = ~t;
      lat          = 1;
      checks++;
      if (busy_o !== 1'b1) begin
         failures++;
         $display("FAIL %s busy_rise: busy_o=%b expected 1", name, busy_o);
      end
      while (valid_o !== 1'b1 && lat < 300) begin
         if (lat == extra_cyc) begin
            start_i      = 1'b1;
            posix_time_i = extra_t;
         end
         @(negedge clk_i);
         start_i = 1'b0;
         lat++;
      end
      checks++;
      if (lat !== 133) begin
         failures++;
         $display("FAIL %s latency: valid_o at cycle %0d expected 133", name, lat);
      end
      checks++;
      if (busy_o !== 1'b0) begin
         failures++;
         $display("FAIL %s busy_fall: busy_o=%b expected 0", name, busy_o);
      end
      checks++;
      if (hour_o !== 5'(exp_h) || min_o !== 6'(exp_m) || sec_o !== 6'(exp_s)) begin
         failures++;
         $display("FAIL %s hms: got %0d:%0d:%0d expected %0d:%0d:%0d",
                  name, hour_o, min_o, sec_o, exp_h, exp_m, exp_s);
      end
      checks++;
      if (dow_o !== 3'(exp_dow) || days_o !== 16'(exp_days)) begin
         failures++;
         $display("FAIL %s dow_days: got dow=%0d days=%0d expected dow=%0d days=%0d",
                  name, dow_o, days_o, exp_dow, exp_days);
      end
      repeat (3) @(negedge clk_i);
      checks++;
      if (valid_o !== 1'b0 || hour_o !== 5'(exp_h) || min_o !== 6'(exp_m) ||
          sec_o !== 6'(exp_s) || days_o !== 16'(exp_days)) begin
         failures++;
         $display("FAIL %s hold: valid=%b %0d:%0d:%0d days=%0d expected valid=0 %0d:%0d:%0d days=%0d",
                  name, valid_o, hour_o, min_o, sec_o, days_o, exp_h, exp_m, exp_s, exp_days);
      end
      checks++;
      if (valid_cnt - v0 !== 1) begin
         failures++;
         $display("FAIL %s pulse_count: got %0d valid pulses expected 1", name, valid_cnt - v0);
      end
   endtask

   task automatic test_reset();
      rst_i        = 1'b1;
      start_i      = 1'b0;
      posix_time_i = '0;
      repeat (3) @(negedge clk_i);
      checks++;
      if (busy_o !== 1'b0 || valid_o !== 1'b0) begin
         failures++;
         $display("FAIL reset_flags: busy=%b valid=%b expected 0 0", busy_o, valid_o);
      end
      checks++;
      if (hour_o !== 5'd0 || min_o !== 6'd0 || sec_o !== 6'd0 || dow_o !== 3'd4 || days_o !== 16'd0) begin
         failures++;
         $display("FAIL reset_outputs: got %0d:%0d:%0d dow=%0d days=%0d expected 0:0:0 dow=4 days=0",
                  hour_o, min_o, sec_o, dow_o, days_o);
      end
      rst_i = 1'b0;
      @(negedge clk_i);
   endtask

   task automatic test_zero();
      run_conv("zero", 32'd0, 0, 0, 0, 4, 0, -1, 32'd0);
   endtask

   task automatic test_day_boundary();
      run_conv("eod", 32'd86399, 23, 59, 59, 4, 0, -1, 32'd0);
      run_conv("sod", 32'd86400, 0, 0, 0, 5, 1, -1, 32'd0);
   endtask

   task automatic test_known_dates();
      run_conv("t1700m", 32'd1700000000, 22, 13, 20, 2, 19675, -1, 32'd0);
      run_conv("max", 32'hFFFF_FFFF, 6, 28, 15, 0, 49710, -1, 32'd0);
   endtask

   // A start pulse mid-conversion must not disturb the running result or queue another.
   task automatic test_ignore_start();
      run_conv("ignore_start", 32'd1700000000, 22, 13, 20, 2, 19675, 50, 32'd86399);
   endtask

   task automatic test_reset_abort();
      int v0;
      @(negedge clk_i);
      v0           = valid_cnt;
      posix_time_i = 32'd86400;
      start_i      = 1'b1;
      @(negedge clk_i);
      start_i      = 1'b0;
      repeat (69) @(negedge clk_i);
      checks++;
      if (busy_o !== 1'b1) begin
         failures++;
         $display("FAIL abort_busy_before: busy_o=%b expected 1", busy_o);
      end
      rst_i = 1'b1;
      #1;
      checks++;
      if (busy_o !== 1'b0 || valid_o !== 1'b0 || hour_o !== 5'd0 || min_o !== 6'd0 ||
          sec_o !== 6'd0 || dow_o !== 3'd4 || days_o !== 16'd0) begin
         failures++;
         $display("FAIL abort_outputs: busy=%b valid=%b %0d:%0d:%0d dow=%0d days=%0d expected 0 0 0:0:0 dow=4 days=0",
                  busy_o, valid_o, hour_o, min_o, sec_o, dow_o, days_o);
      end
      @(negedge clk_i);
      rst_i = 1'b0;
      repeat (100) @(negedge clk_i);
      checks++;
      if (valid_cnt !== v0 || busy_o !== 1'b0) begin
         failures++;
         $display("FAIL abort_no_valid: pulses=%0d busy=%b expected 0 0", valid_cnt - v0, busy_o);
      end
      run_conv("after_abort", 32'd86399, 23, 59, 59, 4, 0, -1, 32'd0);
   endtask

   initial begin
      test_reset();
      test_zero();
      test_day_boundary();
      test_known_dates();
      test_ignore_start();
      test_reset_abort();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
